// File: rtl/shift_reg_piso_pkg.sv
// Shared constants and types for the parallel-in serial-out shifter.
// Holds the counter width helper and the per-edge action encoding.
package shift_reg_piso_pkg;

   // Kind of work done on a rising edge once out of reset.
   typedef enum logic {
      EDGE_SHIFT = 1'b0,
      EDGE_LOAD  = 1'b1
   } edge_e;

   // A 1-bit counter is still needed when the word is two bits wide.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/shift_reg_piso_bitcnt.sv
// Modulo-size bit counter that frames each serial word.
// wrap marks the last bit of a frame; the top level reloads on it.
module shift_reg_piso_bitcnt
   import shift_reg_piso_pkg::*;
#(
   parameter int size = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   output logic wrap
);

   localparam int CNT_W = cnt_width(size);

   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;

   assign wrap = (cnt_reg == CNT_W'(size - 1));

   // Held at zero until the first word is loaded, then restarts on every wrap.
   always_comb begin
      cnt_next = cnt_reg + CNT_W'(1);
      if (!run || wrap) begin
         cnt_next = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

endmodule

// File: rtl/shift_reg_piso.sv
// Parallel-in serial-out shift register with self-timed framing.
// A word is captured every size cycles and sent one bit per cycle.
module shift_reg_piso
   import shift_reg_piso_pkg::*;
#(
   parameter int size      = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [size-1:0] datain,
   output logic            dataout
);

   logic [size-1:0] sr_reg;
   logic [size-1:0] sr_next;
   logic [size-1:0] shifted;
   logic            loaded_reg;
   logic            wrap;
   edge_e           edge_kind;

   shift_reg_piso_bitcnt #(
      .size (size)
   ) u_bitcnt (
      .clk   (clk),
      .reset (reset),
      .run   (loaded_reg),
      .wrap  (wrap)
   );

   assign edge_kind = (!loaded_reg || wrap) ? EDGE_LOAD : EDGE_SHIFT;

   // Shift away from the leading end, zero-filling the vacated bit.
   genvar gi;
   generate
      for (gi = 0; gi < size; gi++) begin : g_shift
         if (MSB_FIRST) begin : g_left
            if (gi == 0) begin : g_fill
               assign shifted[gi] = 1'b0;
            end else begin : g_move
               assign shifted[gi] = sr_reg[gi-1];
            end
         end else begin : g_right
            if (gi == size - 1) begin : g_fill
               assign shifted[gi] = 1'b0;
            end else begin : g_move
               assign shifted[gi] = sr_reg[gi+1];
            end
         end
      end
   endgenerate

   always_comb begin
      sr_next = shifted;
      if (edge_kind == EDGE_LOAD) begin
         sr_next = datain;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sr_reg     <= '0;
         loaded_reg <= 1'b0;
      end else begin
         sr_reg     <= sr_next;
         loaded_reg <= 1'b1;
      end
   end

   // The leading bit comes straight from the register, so datain never reaches dataout.
   assign dataout = MSB_FIRST ? sr_reg[size-1] : sr_reg[0];

endmodule

// File: tb/tb_shift_reg_piso.sv
// Directed bench for shift_reg_piso: MSB-first and LSB-first 8-bit, plus MSB-first 2-bit.
// Expected bits are queued when a load edge samples datain and popped once per cycle.
module tb_shift_reg_piso;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] din8 = 8'hDD;
   logic [7:0] dinl = 8'hDD;
   logic [1:0] din2 = 2'b10;
   logic       dout8;
   logic       doutl;
   logic       dout2;

   int errors = 0;
   int checks = 0;

   bit exp8[$];
   bit expl[$];
   bit exp2[$];
   int ph8 = 0;
   int phl = 0;
   int ph2 = 0;

   always #5 clk = ~clk;

   shift_reg_piso #(.size(8), .MSB_FIRST(1'b1)) u8 (
      .clk (clk), .reset (reset), .datain (din8), .dataout (dout8)
   );

   shift_reg_piso #(.size(8), .MSB_FIRST(1'b0)) ul (
      .clk (clk), .reset (reset), .datain (dinl), .dataout (doutl)
   );

   shift_reg_piso #(.size(2), .MSB_FIRST(1'b1)) u2 (
      .clk (clk), .reset (reset), .datain (din2), .dataout (dout2)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic pop_check(input string tag, input logic got, inout bit q[$]);
      logic e;
      if (q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: observed %b expected queued bit (queue empty)", tag, got);
      end else begin
         e = q.pop_front();
         check(tag, {7'd0, got}, {7'd0, e});
      end
   endtask

   // One clock cycle: queue the word a load edge will take, then compare after the edge.
   task automatic tick(input string tag);
      if (reset) begin
         if (ph8 == 0) for (int i = 7; i >= 0; i--) exp8.push_back(din8[i]);
         if (phl == 0) for (int i = 0; i < 8; i++) expl.push_back(dinl[i]);
         if (ph2 == 0) for (int i = 1; i >= 0; i--) exp2.push_back(din2[i]);
         ph8 = (ph8 + 1) % 8;
         phl = (phl + 1) % 8;
         ph2 = (ph2 + 1) % 2;
      end
      @(posedge clk);
      #1;
      if (!reset) begin
         check({tag, "_rst_msb8"}, {7'd0, dout8}, 8'd0);
         check({tag, "_rst_lsb8"}, {7'd0, doutl}, 8'd0);
         check({tag, "_rst_msb2"}, {7'd0, dout2}, 8'd0);
      end else begin
         pop_check({tag, "_msb8"}, dout8, exp8);
         pop_check({tag, "_lsb8"}, doutl, expl);
         pop_check({tag, "_msb2"}, dout2, exp2);
      end
      $display("cycle %s: msb8=%b lsb8=%b msb2=%b din8=%h din2=%b", tag, dout8, doutl, dout2, din8, din2);
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_dout8"}, {7'd0, dout8}, 8'd0);
      check({tag, "_doutl"}, {7'd0, doutl}, 8'd0);
      check({tag, "_dout2"}, {7'd0, dout2}, 8'd0);
      check({tag, "_sr8"}, u8.sr_reg, 8'h00);
      check({tag, "_cnt8"}, {5'd0, u8.u_bitcnt.cnt_reg}, 8'd0);
      check({tag, "_loaded8"}, {7'd0, u8.loaded_reg}, 8'd0);
   endtask

   initial begin
      // Reset held low with a non-zero word on the bus.
      #2;
      check_cleared("reset_init");
      repeat (3) tick("reset_hold");
      check_cleared("reset_hold_end");

      // Release between edges; the next edge is a load edge.
      reset = 1'b1;
      repeat (16) tick("frames_dd");

      // Word change during cycle 3: this frame still sends DD.
      repeat (3) tick("frame3_pre");
      din8 = 8'h0F;
      din2 = 2'b01;
      repeat (5) tick("frame3_post");

      // Next frame carries 0F: 0,0,0,0,1,1,1,1.
      repeat (8) tick("frame4_0f");

      // Abort after four bits; reset clears everything at once.
      repeat (4) tick("frame5_part");
      reset = 1'b0;
      #1;
      check_cleared("midframe_rst");
      exp8.delete();
      expl.delete();
      exp2.delete();
      ph8 = 0;
      phl = 0;
      ph2 = 0;
      repeat (2) tick("midframe_hold");

      // Full word restarts from its first bit.
      reset = 1'b1;
      repeat (8) tick("restart_0f");
      din2 = 2'b11;
      repeat (4) tick("tail");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shift_reg_piso.md
# shift_reg_piso

Parallel-in, serial-out shift register with automatic framing. Every `size` clock cycles it captures the parallel word on `datain` and then serialises it one bit per cycle on `dataout`, MSB first by default. It sits at the boundary between a parallel data path and a single-wire serial link. No load strobe is used: an internal bit counter defines the frame.

## Interface
- `size`, default 8: word width in bits; legal range is 2 and above.
- `MSB_FIRST`, default 1: 1 sends `datain[size-1]` first; 0 sends `datain[0]` first.

- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- `datain`  input  `size`  parallel word; sampled only on load edges.
- `dataout`  output  1  serial bit, driven directly from a register.

## Operation
- State:
  - shift register `sr[size-1:0]`;
  - bit counter `cnt`, width `$clog2(size)`, counting 0..`size`-1;
  - `loaded` flag, cleared by reset.
- Reset (`reset`=0):
  - `sr`, `cnt` and `loaded` are cleared to 0 immediately.
  - `dataout` = 0.
- Load edge: first rising edge with `reset`=1 and `loaded`=0, or any edge with `cnt`=`size`-1.
  - `sr` <= `datain`; `cnt` <= 0; `loaded` <= 1.
  - After the edge, `dataout` = first bit of `datain`: bit `size`-1 if `MSB_FIRST`, else bit 0.
- Shift edge: all other edges with `loaded`=1.
  - If `MSB_FIRST`, `sr` shifts left and a 0 enters at bit 0; else it shifts right and a 0 enters at the top.
  - `cnt` increments by 1.
  - `dataout` = current leading bit of `sr`.
- Continuous framing: each frame is exactly `size` cycles, and frames follow back-to-back with no idle bit.
- Changes on `datain` between load edges have no effect.

## Timing
- Latency: the first serial bit appears one edge after reset release. Bit k of the frame (k = 0..`size`-1) is valid for the cycle after edge k of that frame.
- A reset asserted mid-frame aborts the frame at once, with no partial output.
- After reset release, the next edge is a fresh load edge.
- Reset deassertion must be synchronised to `clk` outside this block.
- No combinational path from `datain` to `dataout`.
- `cnt` wraps from `size`-1 to 0 on the load edge only; it never reaches `size`.

## Structure
- No shared package is required. `CNT_W = $clog2(size)` is a local constant.
- One sub-module is natural: `shift_reg_piso_bitcnt`.
  - A modulo-`size` counter with async active-low clear.
  - Outputs a `wrap` pulse (`cnt`==`size`-1) that the top level uses as its load enable.

## Test plan
- Reset: pulse `reset` low with `datain`=8'hDD -> `dataout`=0 while low; `sr` and `cnt` read 0.
- Basic serialisation: `size`=8, `datain`=8'b11011101, release reset -> `dataout` over the next 8 cycles is 1,1,0,1,1,1,0,1.
- Reload: hold `datain`=8'b11011101 for 16 cycles -> the 8-bit pattern repeats twice with no gap or stall.
- Word change: change `datain` to 8'h0F during cycle 3 of a frame -> the current frame is unaffected; the next frame sends 0,0,0,0,1,1,1,1.
- Mid-frame reset: assert `reset` low after 4 bits -> `dataout` drops to 0 immediately; after release, the full word restarts from its first bit.
- LSB-first: `MSB_FIRST`=0, `datain`=8'b11011101 -> output is 1,0,1,1,1,0,1,1. Also check `size`=2, where every second edge is a load edge.
